// File: rtl/voting_tally_ctrl.sv
// Sequential ballot controller: takes one vote per cycle, then scans the tallies and publishes the winner.
// Optional macro VOTING_TALLY_TIE_EN enables the tie output; when it is undefined, tie is held at 0.
module voting_tally_ctrl #(
  parameter int N = 2,
  parameter int M = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         close,
  input  logic         vote_valid,
  input  logic [N-1:0] vote,
  output logic         vote_ready,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] winner,
  output logic [M:0]   winner_count,
  output logic         tie
);

  localparam int unsigned NCAND     = 1 << N;
  localparam int unsigned MAX_INT   = 1 << M;
  localparam int unsigned LAST_V    = MAX_INT - 1;
  localparam int unsigned LAST_I    = NCAND - 1;
  localparam int unsigned ONE_INT   = 1;
  localparam logic [M:0]   MAX_VOTES = MAX_INT[M:0];
  localparam logic [M:0]   LAST_VOTE = LAST_V[M:0];
  localparam logic [M:0]   CNT_ONE   = ONE_INT[M:0];
  localparam logic [N-1:0] LAST_IDX  = LAST_I[N-1:0];
  localparam logic [N-1:0] IDX_ONE   = ONE_INT[N-1:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_SCAN,
    S_DONE
  } state_e;

  state_e       state_q, state_d;
  logic [M:0]   tally_q [NCAND];
  logic [M:0]   tally_d [NCAND];
  logic [M:0]   total_q, total_d;
  logic [N-1:0] scan_idx_q, scan_idx_d;
  logic [N-1:0] best_idx_q, best_idx_d;
  logic [M:0]   best_cnt_q, best_cnt_d;
  logic [N-1:0] winner_q, winner_d;
  logic [M:0]   winner_count_q, winner_count_d;
  logic [M:0]   cur_cnt;
  logic         accept;
`ifdef VOTING_TALLY_TIE_EN
  logic         tie_scan_q, tie_scan_d;
  logic         tie_q, tie_d;
`endif

  // Every output is a decode of registered state only, so no input reaches an output combinationally.
  assign vote_ready   = (state_q == S_COLLECT) && (total_q < MAX_VOTES);
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign winner       = winner_q;
  assign winner_count = winner_count_q;
`ifdef VOTING_TALLY_TIE_EN
  assign tie          = tie_q;
`else
  assign tie          = 1'b0;
`endif

  always_comb begin
    // NOTE: every variable written here gets a default first; a path that skips an assignment would infer a latch.
    state_d        = state_q;
    tally_d        = tally_q;
    total_d        = total_q;
    scan_idx_d     = scan_idx_q;
    best_idx_d     = best_idx_q;
    best_cnt_d     = best_cnt_q;
    winner_d       = winner_q;
    winner_count_d = winner_count_q;
`ifdef VOTING_TALLY_TIE_EN
    tie_scan_d     = tie_scan_q;
    tie_d          = tie_q;
`endif
    accept         = 1'b0;
    cur_cnt        = tally_q[scan_idx_q];

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_COLLECT;
          total_d    = '0;
          scan_idx_d = '0;
          best_idx_d = '0;
          best_cnt_d = '0;
          for (int i = 0; i < NCAND; i++) tally_d[i] = '0;
`ifdef VOTING_TALLY_TIE_EN
          tie_scan_d = 1'b0;
`endif
        end
      end

      S_COLLECT: begin
        accept = vote_valid && vote_ready;
        if (accept) begin
          tally_d[vote] = tally_q[vote] + CNT_ONE;
          total_d       = total_q + CNT_ONE;
        end
        // A vote arriving together with close is still counted before the ballot shuts.
        if (close || (accept && (total_q == LAST_VOTE))) begin
          state_d    = S_SCAN;
          scan_idx_d = '0;
        end
      end

      S_SCAN: begin
        if (scan_idx_q == '0) begin
          best_idx_d = '0;
          best_cnt_d = cur_cnt;
`ifdef VOTING_TALLY_TIE_EN
          tie_scan_d = 1'b0;
`endif
        end else if (cur_cnt > best_cnt_q) begin
          best_idx_d = scan_idx_q;
          best_cnt_d = cur_cnt;
`ifdef VOTING_TALLY_TIE_EN
          tie_scan_d = 1'b0;
`endif
        end else if (cur_cnt == best_cnt_q) begin
`ifdef VOTING_TALLY_TIE_EN
          tie_scan_d = 1'b1;
`endif
        end
        scan_idx_d = scan_idx_q + IDX_ONE;
        // Results are loaded on the way into DONE so they are already valid while done is high.
        if (scan_idx_q == LAST_IDX) begin
          state_d        = S_DONE;
          winner_d       = best_idx_d;
          winner_count_d = best_cnt_d;
`ifdef VOTING_TALLY_TIE_EN
          tie_d          = tie_scan_d;
`endif
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the tally array is a small register file, not RAM, so it is cleared by reset like any other state.
      state_q        <= S_IDLE;
      total_q        <= '0;
      scan_idx_q     <= '0;
      best_idx_q     <= '0;
      best_cnt_q     <= '0;
      winner_q       <= '0;
      winner_count_q <= '0;
      for (int i = 0; i < NCAND; i++) tally_q[i] <= '0;
`ifdef VOTING_TALLY_TIE_EN
      tie_scan_q     <= 1'b0;
      tie_q          <= 1'b0;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state_q        <= state_d;
      tally_q        <= tally_d;
      total_q        <= total_d;
      scan_idx_q     <= scan_idx_d;
      best_idx_q     <= best_idx_d;
      best_cnt_q     <= best_cnt_d;
      winner_q       <= winner_d;
      winner_count_q <= winner_count_d;
`ifdef VOTING_TALLY_TIE_EN
      tie_scan_q     <= tie_scan_d;
      tie_q          <= tie_d;
`endif
    end
  end

endmodule

// File: tb/tb_voting_tally_ctrl.sv
// Self-checking bench for voting_tally_ctrl: a ballot-level model checked every cycle, plus literal results per ballot.
module tb_voting_tally_ctrl;

  localparam int N  = 2;
  localparam int M  = 2;
  localparam int NC = 1 << N;
  localparam int MAXV = 1 << M;
`ifdef VOTING_TALLY_TIE_EN
  localparam bit TIE_EN = 1'b1;
`else
  localparam bit TIE_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         close;
  logic         vote_valid;
  logic [N-1:0] vote;
  logic         vote_ready;
  logic         busy;
  logic         done;
  logic [N-1:0] winner;
  logic [M:0]   winner_count;
  logic         tie;

  int n_total = 0;
  int n_pass  = 0;

  voting_tally_ctrl #(.N(N), .M(M)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .close        (close),
    .vote_valid   (vote_valid),
    .vote         (vote),
    .vote_ready   (vote_ready),
    .busy         (busy),
    .done         (done),
    .winner       (winner),
    .winner_count (winner_count),
    .tie          (tie)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Ballot-level model: counts votes, and on close picks the winner directly from the final tallies.
  bit         m_open = 1'b0;
  bit         m_done = 1'b0;
  int         m_scan_left = 0;
  int         m_cnt [NC];
  int         m_total = 0;
  logic [N-1:0] m_w = '0, p_w = '0;
  logic [M:0]   m_c = '0, p_c = '0;
  logic         m_t = 1'b0, p_t = 1'b0;

  initial begin
    for (int i = 0; i < NC; i++) m_cnt[i] = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_open = 1'b0; m_done = 1'b0; m_scan_left = 0; m_total = 0;
        m_w = '0; m_c = '0; m_t = 1'b0;
        for (int i = 0; i < NC; i++) m_cnt[i] = 0;
      end else if (m_done) begin
        m_done = 1'b0;
      end else if (m_scan_left > 0) begin
        m_scan_left--;
        if (m_scan_left == 0) begin
          m_done = 1'b1; m_w = p_w; m_c = p_c; m_t = p_t;
        end
      end else if (m_open) begin
        bit acc;
        acc = vote_valid && (m_total < MAXV);
        if (acc) begin
          m_cnt[vote]++;
          m_total++;
        end
        if (close || (acc && m_total == MAXV)) begin
          int best, bi, nmax;
          best = -1; bi = 0; nmax = 0;
          for (int i = 0; i < NC; i++) if (m_cnt[i] > best) begin best = m_cnt[i]; bi = i; end
          for (int i = 0; i < NC; i++) if (m_cnt[i] == best) nmax++;
          p_w = N'(bi); p_c = (M+1)'(best); p_t = TIE_EN && (nmax > 1);
          m_open = 1'b0;
          m_scan_left = NC;
        end
      end else if (start) begin
        m_open = 1'b1; m_total = 0;
        for (int i = 0; i < NC; i++) m_cnt[i] = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic [63:0] act, exp;
    act = 64'({vote_ready, busy, done, winner, winner_count, tie});
    exp = 64'({m_open && (m_total < MAXV), m_open || (m_scan_left > 0) || m_done, m_done, m_w, m_c, m_t});
    check("cycle_outputs", act, exp);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 50) begin
      tick();
      n++;
    end
    if (!done) check("done_timeout", 64'(done), 64'd1);
  endtask

  // Waits for done, checks latency and literal results, then steps into the following IDLE cycle.
  task automatic finish_ballot(input string name, input int already, input int w, input int c, input bit t);
    int n;
    wait_done(n);
    check({name, "_latency"}, 64'(n + already), 64'(NC));
    check({name, "_winner"}, 64'(winner), 64'(w));
    check({name, "_count"}, 64'(winner_count), 64'(c));
    check({name, "_tie"}, 64'(tie), 64'(t));
    vote_valid = 1'b0;
    tick();
    check({name, "_idle_after"}, 64'({busy, done}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; close = 1'b0; vote_valid = 1'b0; vote = '0;
    #2;
    check("reset_outputs", 64'({vote_ready, busy, done, winner, winner_count, tie}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Ballot 1: four votes auto-close the ballot; a further vote is dropped.
    start = 1'b1; tick(); start = 1'b0;
    check("b1_ready_open", 64'(vote_ready), 64'd1);
    vote_valid = 1'b1;
    vote = 2'd2; tick();
    vote = 2'd2; tick();
    vote = 2'd1; tick();
    vote = 2'd3; tick();
    check("b1_ready_full", 64'({vote_ready, busy}), 64'b01);
    vote = 2'd0;
    finish_ballot("b1", 0, 2, 2, 1'b0);

    // Ballot 2: votes 1 and 3 then close -> equal tallies, lowest index wins.
    start = 1'b1; tick(); start = 1'b0;
    vote_valid = 1'b1;
    vote = 2'd1; tick();
    vote = 2'd3; tick();
    vote_valid = 1'b0; close = 1'b1; tick(); close = 1'b0;
    finish_ballot("b2", 0, 1, 1, TIE_EN);

    // Ballot 3: zero votes.
    start = 1'b1; tick(); start = 1'b0;
    close = 1'b1; tick(); close = 1'b0;
    finish_ballot("b3", 0, 0, 0, TIE_EN);

    // Ballot 4: vote together with close is counted.
    start = 1'b1; tick(); start = 1'b0;
    vote_valid = 1'b1; vote = 2'd3; close = 1'b1; tick();
    vote_valid = 1'b0; close = 1'b0;
    finish_ballot("b4", 0, 3, 1, 1'b0);

    // Ballot 5: reset mid-collect discards the ballot and clears held results.
    start = 1'b1; tick(); start = 1'b0;
    vote_valid = 1'b1; vote = 2'd0; tick(); tick();
    vote_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_async_outputs", 64'({vote_ready, busy, done, winner, winner_count, tie}), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    vote_valid = 1'b1; vote = 2'd1;
    tick(); tick(); tick();
    check("rst_votes_ignored", 64'({vote_ready, busy}), 64'd0);
    vote_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    vote_valid = 1'b1; vote = 2'd2; close = 1'b1; tick();
    vote_valid = 1'b0; close = 1'b0;
    finish_ballot("b5", 0, 2, 1, 1'b0);

    // Ballot 6: start and close pulsed during SCAN are ignored.
    start = 1'b1; tick(); start = 1'b0;
    vote_valid = 1'b1;
    vote = 2'd1; tick();
    vote = 2'd1; tick();
    vote = 2'd0; tick();
    vote_valid = 1'b0; close = 1'b1; tick(); close = 1'b0;
    start = 1'b1; close = 1'b1; tick();
    start = 1'b0; close = 1'b0; tick();
    finish_ballot("b6", 2, 1, 2, 1'b0);
    tick();
    check("b6_no_restart", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/voting_tally_ctrl.md
# voting_tally_ctrl

Sequential ballot controller for the voting circuits. It accepts one vote per cycle over a valid/ready handshake and keeps a per-candidate tally. When the ballot closes, it scans the tallies over successive cycles and publishes the winner, the winning count and a tie indication. It is the stateful front end that sequences vote collection and winner selection, as opposed to the all-votes-at-once combinational voting datapath.

## Interface
- N, 2: log2 of number of candidates (2^N candidates)
- M, 2: log2 of maximum number of voters (2^M votes per ballot)

- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  opens a new ballot; honoured only in IDLE
- close  in  1  ends the ballot early; honoured only in COLLECT
- vote_valid  in  1  vote present on `vote`
- vote  in  N  candidate index voted for
- vote_ready  out  1  controller accepts a vote this cycle
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse; result outputs are valid
- winner  out  N  winning candidate index
- winner_count  out  M+1  tally of the winner
- tie  out  1  another candidate's tally equals winner_count

## Operation
- States: IDLE, COLLECT, SCAN, DONE.
- Tallies: 2^N counters, each M+1 bits wide. The total-vote counter is also M+1 bits. No counter can exceed 2^M, so no wrap is possible.
- IDLE -> COLLECT when start=1. All tallies, the total counter and the scan registers clear on this transition.
- COLLECT:
  - vote_ready=1 while total < 2^M.
  - When vote_valid && vote_ready: tally[vote]++ and total++.
  - COLLECT -> SCAN when close=1, or when an accept brings total to 2^M (auto-close).
  - If close and an accepted vote occur in the same cycle, the vote is counted.
  - vote_valid with vote_ready=0 is dropped and has no effect.
- SCAN:
  - Index i steps 0..2^N-1, one candidate per cycle. best_idx and best_cnt start at index 0.
  - tally[i] > best_cnt: update best and clear the tie flag.
  - tally[i] == best_cnt with i>0: set the tie flag.
  - Ties resolve to the lowest index.
  - After i = 2^N-1, go to DONE.
- DONE: lasts one cycle. Register winner, winner_count and tie; assert done; then go to IDLE.
- Result outputs hold their values until the next DONE. They are not cleared by start.
- start outside IDLE and close outside COLLECT are ignored.
- Zero-vote ballot: winner=0, winner_count=0, tie=1 when N>0.
- Reset (asynchronous, any state):
  - State returns to IDLE; all counters clear.
  - Outputs: vote_ready=0, busy=0, done=0, winner=0, winner_count=0, tie=0.
  - A ballot interrupted by reset is discarded. A new start is required.

## Timing
- start sampled at edge t0 -> vote_ready=1 from t0+1.
- Vote accepted at an edge -> tally visible to SCAN from the following cycle. Throughput is one vote per cycle.
- close, or the final accept, at edge tc -> SCAN occupies cycles tc+1 .. tc+2^N. done=1 in cycle tc+2^N+1, with results valid from that same cycle.
- busy=1 from t0+1 through the done cycle. busy=0 the cycle after done. start in that cycle is accepted.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- VOTING_TALLY_TIE_EN:
  - Defined: tie is computed as described above.
  - Undefined: the tie logic is removed and tie is held at 0. Winner selection is unchanged (lowest index on equal tallies).

## Test plan
- N=2, M=2; start, then votes 2,2,1,3 on consecutive cycles, no close -> auto-close after the 4th accept. vote_ready=0 after the 4th accept. done 5 cycles later with winner=2, winner_count=2, tie=0.
- Start, then votes 1,3, then close -> winner=1, winner_count=1, tie=1 (tie=0 when VOTING_TALLY_TIE_EN is undefined).
- Start, then close immediately with no votes -> done after 4 SCAN cycles; winner=0, winner_count=0, tie=1.
- Start, vote 3 with close asserted in the same cycle -> the vote is counted; winner=3, winner_count=1, tie=0.
- Start, votes 0,0, then rst_n low for 1 cycle -> all outputs 0 immediately. vote_valid afterwards is ignored until a new start. A new ballot with vote 2 and close gives winner=2, winner_count=1.
- start and close pulsed during SCAN -> both ignored; done timing and results unchanged.
